// File: rtl/ahb_lite_mem.sv
// AHB-Lite slave memory model: pipelined single transfers, optional wait states,
// and a two-cycle ERROR response for addresses beyond the word array.
module ahb_lite_mem #(
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int unsigned Depth      = 2 ** MEM_AW;
    localparam logic [1:0]  TransNonseq = 2'b10;
    localparam logic [1:0]  TransSeq    = 2'b11;
    // Counter is loaded with WAIT_STATES-1 so the last wait cycle sees zero.
    localparam logic [3:0]  WaitLoad    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e              state_q;
    logic [MEM_AW-1:0]   addr_q;
    logic                write_q;
    logic [3:0]          wait_cnt_q;
    logic [31:0]         mem [Depth];

    logic accept;
    logic range_err;
    logic unused_inputs;

    assign accept        = HSEL && (HTRANS == TransNonseq || HTRANS == TransSeq);
    assign range_err     = |HADDR[31:MEM_AW];
    assign unused_inputs = ^{HBURST, HSIZE};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wait_cnt_q <= 4'd0;
            HREADY     <= 1'b1;
            HRESP      <= 1'b0;
        end else if (HREADY) begin
            // Previous data phase (if any) completes here; sample the next address phase.
            if (accept) begin
                addr_q  <= HADDR[MEM_AW-1:0];
                write_q <= HWRITE;
                if (range_err) begin
                    state_q <= StErr1;
                    HREADY  <= 1'b0;
                    HRESP   <= 1'b1;
                end else if (WAIT_STATES > 0) begin
                    state_q    <= StWait;
                    wait_cnt_q <= WaitLoad;
                    HREADY     <= 1'b0;
                    HRESP      <= 1'b0;
                end else begin
                    state_q <= StData;
                    HREADY  <= 1'b1;
                    HRESP   <= 1'b0;
                end
            end else begin
                state_q <= StIdle;
                HREADY  <= 1'b1;
                HRESP   <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StWait: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= StData;
                        HREADY  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StErr1: begin
                    state_q <= StErr2;
                    HREADY  <= 1'b1;
                    HRESP   <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    HREADY  <= 1'b1;
                    HRESP   <= 1'b0;
                end
            endcase
        end
    end

    // StData is only ever entered with HREADY high, so this edge ends the data phase.
    always_ff @(posedge HCLK) begin
        if (state_q == StData && write_q) begin
            mem[addr_q] <= HWDATA;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (state_q == StData && !write_q) begin
            HRDATA = mem[addr_q];
        end
    end

endmodule

// File: tb/tb_ahb_lite_mem.sv
// Randomised bench for ahb_lite_mem: two instances (0 and 2 wait states) driven by a
// transaction queue and checked against a word-array model with per-transfer timing.
module tb_ahb_lite_mem;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        hsel;
    logic        use_ws2;

    logic [31:0] hrdata0, hrdata2;
    logic        hready0, hready2, hresp0, hresp2;
    logic [31:0] a_hrdata;
    logic        a_hready, a_hresp;

    assign a_hrdata = use_ws2 ? hrdata2 : hrdata0;
    assign a_hready = use_ws2 ? hready2 : hready0;
    assign a_hresp  = use_ws2 ? hresp2  : hresp0;

    ahb_lite_mem #(.MEM_AW(8), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HSEL(hsel && !use_ws2), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
    );

    ahb_lite_mem #(.MEM_AW(8), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HSEL(hsel && use_ws2), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          rst;
        bit          sel;
        logic [1:0]  trans;
        bit          write;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        q[$];
    logic [31:0] mdata [2][256];
    bit          mvalid[2][256];
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (dut ws=%0d, t=%0t)",
                     tag, got, exp, use_ws2 ? 2 : 0, $time);
        end
    endtask

    function automatic void push(bit rst, bit sel, logic [1:0] trans, bit wr,
                                 logic [31:0] addr, logic [31:0] data);
        txn_t t;
        t.rst = rst; t.sel = sel; t.trans = trans; t.write = wr; t.addr = addr; t.data = data;
        q.push_back(t);
    endfunction

    function automatic void push_wr(logic [31:0] addr, logic [31:0] data);
        push(1'b0, 1'b1, 2'b10, 1'b1, addr, data);
    endfunction

    function automatic void push_rd(logic [31:0] addr);
        push(1'b0, 1'b1, 2'b10, 1'b0, addr, 32'h0);
    endfunction

    function automatic void push_rst();
        push(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endfunction

    function automatic void push_random(int n);
        int unsigned r;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            a = 32'($urandom_range(0, 15));
            if (r < 3) begin
                push_rst();
            end else if (r < 13) begin
                push(1'b0, 1'b1, 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            end else if (r < 18) begin
                push(1'b0, 1'b0, 2'b10, 1'($urandom_range(0, 1)), a, $urandom);
            end else begin
                if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 4096)) * 256;
                push(1'b0, 1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), a, $urandom);
            end
        end
    endfunction

    // Each accepted transfer owns a data phase of (wait cycles + 1) cycles; the model
    // tracks only that remaining count, the response kind and the word array.
    task automatic run_queue();
        bit          dp_valid = 1'b0;
        bit          dp_wr, dp_err, exp_rdy, have_ap;
        int unsigned dp_idx;
        int          dp_cnt;
        logic [31:0] dp_data;
        txn_t        ap;
        int          d  = use_ws2 ? 1 : 0;
        int          ws = use_ws2 ? 2 : 0;
        dp_wr = 1'b0; dp_err = 1'b0; dp_idx = 0; dp_cnt = 0; dp_data = '0;
        while (q.size() > 0 || dp_valid) begin
            if (q.size() > 0 && q[0].rst) begin
                HRESETn = 1'b0;
                hsel    = 1'b0;
                HTRANS  = 2'b00;
                #1;
                check_eq("rst_hready", 32'(a_hready), 32'd1);
                check_eq("rst_hresp", 32'(a_hresp), 32'd0);
                check_eq("rst_hrdata", a_hrdata, 32'd0);
                dp_valid = 1'b0;
                void'(q.pop_front());
                @(posedge HCLK);
                @(negedge HCLK);
                HRESETn = 1'b1;
                continue;
            end
            have_ap = q.size() > 0;
            if (have_ap) ap = q[0];
            else ap = '{rst: 1'b0, sel: 1'b0, trans: 2'b00, write: 1'b0, addr: 32'h0, data: 32'h0};
            hsel   = ap.sel;
            HTRANS = ap.trans;
            HADDR  = ap.addr;
            HWRITE = ap.write;
            HBURST = 3'($urandom_range(0, 7));
            HSIZE  = 3'($urandom_range(0, 7));
            HWDATA = dp_valid ? dp_data : $urandom;
            #1;
            exp_rdy = !dp_valid || dp_cnt == 0;
            check_eq("hready", 32'(a_hready), 32'(exp_rdy));
            check_eq("hresp", 32'(a_hresp), 32'(dp_valid && dp_err));
            if (dp_valid && dp_err) check_eq("err_hrdata", a_hrdata, 32'd0);
            if (dp_valid && !dp_err && !dp_wr && exp_rdy && mvalid[d][dp_idx])
                check_eq("hrdata", a_hrdata, mdata[d][dp_idx]);
            @(posedge HCLK);
            if (exp_rdy) begin
                if (dp_valid && !dp_err && dp_wr) begin
                    mdata[d][dp_idx]  = dp_data;
                    mvalid[d][dp_idx] = 1'b1;
                end
                dp_valid = 1'b0;
                if (have_ap) begin
                    void'(q.pop_front());
                    if (ap.sel && ap.trans[1]) begin
                        dp_valid = 1'b1;
                        dp_wr    = ap.write;
                        dp_err   = ap.addr >= 32'd256;
                        dp_idx   = ap.addr % 256;
                        dp_data  = ap.data;
                        dp_cnt   = dp_err ? 1 : ws;
                    end
                end
            end else begin
                dp_cnt--;
            end
            @(negedge HCLK);
        end
        hsel   = 1'b0;
        HTRANS = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        HRESETn  = 1'b0;
        use_ws2  = 1'b0;
        hsel     = 1'b0;
        HTRANS   = 2'b00;
        HADDR    = '0;
        HWRITE   = 1'b0;
        HWDATA   = '0;
        HBURST   = '0;
        HSIZE    = '0;
        repeat (2) @(negedge HCLK);
        check_eq("init_hready0", 32'(hready0), 32'd1);
        check_eq("init_hresp0", 32'(hresp0), 32'd0);
        check_eq("init_hrdata0", hrdata0, 32'd0);
        check_eq("init_hready2", 32'(hready2), 32'd1);
        check_eq("init_hresp2", 32'(hresp2), 32'd0);
        check_eq("init_hrdata2", hrdata2, 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        use_ws2 = 1'b0;
        push_wr(32'h0, 32'h0BAD_F00D);
        push_rd(32'h2);
        push_wr(32'h4, 32'd4);
        push_wr(32'h6, 32'd6);
        push_rd(32'h4);
        push_rd(32'h6);
        push(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        push_rd(32'h4);
        push_rst();
        push_wr(32'd10, 32'hA5A5_A5A5);
        push(1'b0, 1'b1, 2'b00, 1'b1, 32'd10, 32'h0);
        push(1'b0, 1'b1, 2'b01, 1'b1, 32'd10, 32'h0);
        push(1'b0, 1'b0, 2'b10, 1'b1, 32'd10, 32'h0);
        push_rd(32'd10);
        push_wr(32'h100, 32'h0000_DEAD);
        push_rd(32'h0);
        push_wr(32'd7, 32'h55AA_55AA);
        push_rd(32'd7);
        push_wr(32'd7, 32'hAA55_AA55);
        push_rd(32'd7);
        for (int i = 0; i < 16; i++) push_wr(32'(i), $urandom);
        push_random(120);
        run_queue();

        use_ws2 = 1'b1;
        push_wr(32'd3, 32'h1234_5678);
        push_rd(32'd3);
        push_wr(32'd20, 32'h0000_1111);
        push_wr(32'd20, 32'h0000_2222);
        push_rst();
        push_rd(32'd20);
        push_wr(32'h0, 32'h0BAD_F00D);
        push_wr(32'h100, 32'h0000_DEAD);
        push_rd(32'h0);
        push_wr(32'd7, 32'h55AA_55AA);
        push_rd(32'd7);
        push_wr(32'd7, 32'hAA55_AA55);
        push_rd(32'd7);
        for (int i = 0; i < 16; i++) push_wr(32'(i), $urandom);
        push_random(120);
        run_queue();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_mem.md
Name: ahb_lite_mem

Overview:
- Behavioural AHB-Lite slave memory used as a bus-target model when verifying AHB-Lite masters and the SDRAM controller path.
- Accepts single pipelined transfers: address phase, then data phase.
- Writes store HWDATA into an internal word array. Reads return the stored word on HRDATA.
- Supports configurable wait states and an ERROR response for out-of-range addresses.

Parameters:
- MEM_AW, 8: word-index width; memory holds 2**MEM_AW 32-bit words.
- WAIT_STATES, 0: number of HREADY-low cycles inserted at the start of every OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  transfer address, used directly as a word index.
- HBURST  in  3  burst type; accepted and ignored (every transfer handled as single).
- HSEL  in  1  slave select.
- HSIZE  in  3  transfer size; accepted and ignored (always full 32-bit word).
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWDATA  in  32  write data, valid in the data phase.
- HWRITE  in  1  1 write, 0 read.
- HRDATA  out  32  read data.
- HREADY  out  1  transfer-done / slave-ready; also used as the bus HREADY input.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (HRESETn low, async):
  - HREADY=1, HRESP=0, HRDATA=0.
  - Data-phase state cleared to "no transfer", wait counter cleared.
  - Memory array is not cleared; unwritten words read as X.
- Address-phase sampling:
  - Happens on the rising edge where HREADY=1.
  - A transfer is accepted when HSEL=1 and HTRANS is NONSEQ or SEQ.
  - On acceptance, register HADDR[MEM_AW-1:0], HWRITE, and the flag range_err = |HADDR[31:MEM_AW].
  - IDLE, BUSY or HSEL=0 → no data phase follows; HREADY stays 1, HRESP 0.
- OKAY data phase:
  - HREADY=0 for WAIT_STATES cycles, then HREADY=1 for one cycle.
  - Write: mem[addr] <= HWDATA on the edge ending the HREADY=1 cycle.
  - Read: HRDATA = mem[addr], driven combinationally from the registered address, valid while HREADY=1.
  - HRDATA may hold any value outside read data phases; implement it as 0.
- ERROR data phase (range_err=1):
  - Ignores WAIT_STATES.
  - Cycle 1: HREADY=0, HRESP=1. Cycle 2: HREADY=1, HRESP=1.
  - No memory write. HRDATA=0.
  - During ERROR cycle 1, HREADY=0 prevents sampling a new address phase.
- Pipelining:
  - A new address phase is sampled on the same edge that completes the previous data phase.
  - Back-to-back transfers run with no dead cycles when WAIT_STATES=0.
  - A read issued immediately after a write to the same address returns the new data. The write commits at the end of its data phase, before the read's data phase.
- State machine:
  - IDLE → (accept, OK) WAIT if WAIT_STATES>0, else DATA.
  - WAIT → DATA after WAIT_STATES cycles.
  - DATA → WAIT/DATA/ERR1/IDLE depending on the next accepted transfer.
  - IDLE → (accept, range_err) ERR1 → ERR2 → next per new sample.
- Reset mid-transfer aborts the transfer. A write that has not reached its completing edge is not committed.

Test Plan:
- Pipelined sequence, WAIT_STATES=0, MEM_AW=8:
  - Address phases in order: read@2, write@4, write@6, read@4, read@6, idle.
  - HWDATA is 4 in the write@6 address cycle and 6 in the read@4 address cycle.
  - Required: HREADY always 1, HRESP 0; HRDATA=4 in the read@4 data phase and 6 in the read@6 data phase.
- Reset: assert HRESETn=0 mid-sequence → HREADY=1, HRESP=0, HRDATA=0 immediately, with no clock edge needed.
- Idle/unselected:
  - HTRANS=IDLE, then BUSY, then HSEL=0 with HWRITE=1.
  - Required: no memory change (a prior write of 0xA5A5A5A5 @10 still reads back), HREADY stays 1.
- Wait states, WAIT_STATES=2:
  - write 0x12345678 @3, then read @3.
  - Required: each data phase shows exactly 2 HREADY-low cycles, then 1 HREADY-high cycle; the read returns 0x12345678.
- Out of range, MEM_AW=8:
  - write @0x100 with data 0xDEAD, then read @0x00.
  - Required: 2-cycle ERROR response (HREADY 0/1, HRESP 1/1); word 0 is unchanged.
- Back-to-back alternating write/read of 0x55AA55AA then 0xAA55AA55 at the same address → each read returns the immediately preceding write.
